// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned 32-bit multiply (low word) and restoring divide, sequenced through
// the shared combinational ALU one shift step per cycle.
module alu_muldiv_sequencer #(
   parameter int unsigned CommandLength = 3,
   parameter int unsigned Iterations    = 32
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     start_i,
   input  logic                     op_i,
   input  logic [31:0]              operand_a_i,
   input  logic [31:0]              operand_b_i,
   output logic [31:0]              alu_input_1_o,
   output logic [31:0]              alu_input_2_o,
   output logic [CommandLength-1:0] alu_command_o,
   input  logic [31:0]              alu_out_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [31:0]              result_lo_o,
   output logic [31:0]              result_hi_o
);

   localparam logic [CommandLength-1:0] CmdAdd = CommandLength'(0);
   localparam logic [CommandLength-1:0] CmdSub = CommandLength'(1);
   localparam logic [CommandLength-1:0] CmdSlt = CommandLength'(5);
   localparam logic [5:0]               LastCount = 6'(Iterations - 1);

   typedef enum logic [2:0] {StIdle, StMul, StDivCmp, StDivSub, StDone} state_e;

   state_e      state_q, state_d;
   logic [5:0]  count_q, count_d;
   // acc/rem, mcand/quo and mplier/dvsr share storage; only one operation is ever in flight.
   logic [31:0] acc_q, acc_d;
   logic [31:0] mq_q, mq_d;
   logic [31:0] md_q, md_d;
   logic        lt_q, lt_d;
   logic        op_q, op_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic [31:0] res_hi_q, res_hi_d;

   logic [31:0] shifted;
   logic        ovf;

   assign shifted = {acc_q[30:0], mq_q[31]};
   assign ovf     = acc_q[31];

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      acc_d         = acc_q;
      mq_d          = mq_q;
      md_d          = md_q;
      lt_d          = lt_q;
      op_d          = op_q;
      res_lo_d      = res_lo_q;
      res_hi_d      = res_hi_q;
      alu_input_1_o = '0;
      alu_input_2_o = '0;
      alu_command_o = CmdAdd;

      case (state_q)
         StIdle: begin
            if (start_i) begin
               op_d    = op_i;
               count_d = '0;
               acc_d   = '0;
               mq_d    = operand_a_i;
               md_d    = operand_b_i;
               lt_d    = 1'b0;
               state_d = op_i ? StDivCmp : StMul;
            end
         end
         StMul: begin
            alu_input_1_o = acc_q;
            alu_input_2_o = mq_q;
            if (md_q[0]) begin
               acc_d = alu_out_i;
            end
            mq_d    = {mq_q[30:0], 1'b0};
            md_d    = {1'b0, md_q[31:1]};
            count_d = count_q + 6'd1;
            if (count_q == LastCount) begin
               state_d = StDone;
            end
         end
         StDivCmp: begin
            alu_input_1_o = shifted;
            alu_input_2_o = md_q;
            alu_command_o = CmdSlt;
            // A set top bit means the true shifted value exceeds any divisor.
            lt_d    = alu_out_i[0] & ~ovf;
            acc_d   = shifted;
            mq_d    = {mq_q[30:0], 1'b0};
            state_d = StDivSub;
         end
         StDivSub: begin
            alu_input_1_o = acc_q;
            alu_input_2_o = md_q;
            alu_command_o = CmdSub;
            if (!lt_q) begin
               acc_d   = alu_out_i;
               mq_d[0] = 1'b1;
            end
            count_d = count_q + 6'd1;
            state_d = (count_q == LastCount) ? StDone : StDivCmp;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Results are captured on entry so they are already visible during the done cycle.
      if (state_d == StDone) begin
         res_lo_d = op_q ? mq_d : acc_d;
         res_hi_d = op_q ? acc_d : 32'd0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= StIdle;
         count_q  <= '0;
         acc_q    <= '0;
         mq_q     <= '0;
         md_q     <= '0;
         lt_q     <= 1'b0;
         op_q     <= 1'b0;
         res_lo_q <= '0;
         res_hi_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         mq_q     <= mq_d;
         md_q     <= md_d;
         lt_q     <= lt_d;
         op_q     <= op_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
      end
   end

   assign busy_o      = (state_q == StMul) || (state_q == StDivCmp) || (state_q == StDivSub);
   assign done_o      = (state_q == StDone);
   assign result_lo_o = res_lo_q;
   assign result_hi_o = res_hi_q;

endmodule

// File: doc/alu_muldiv_sequencer.md
Name: alu_muldiv_sequencer

Overview:
Multi-cycle controller that implements MIPS-style unsigned 32-bit multiply (low word) and divide (quotient and remainder) by sequencing the shared combinational ALU over many cycles. It drives the ALU operand and command inputs and consumes the ALU result. It sits beside the main datapath; the CPU control unit starts an operation and stalls on busy until done.

Parameters:
command_length, 3, width of the ALU command bus
iterations, 32, operand width and number of shift steps; the design is fixed at 32

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; accepted only in IDLE
op  input  1  0 = multiply, 1 = divide; sampled with start
operand_a  input  32  multiplicand or dividend; sampled with start
operand_b  input  32  multiplier or divisor; sampled with start
alu_input_1  output  32  ALU operand 1 (combinational from state/regs)
alu_input_2  output  32  ALU operand 2
alu_command  output  command_length  ALU command: add=000, sub=001, SLT=101
alu_out  input  32  ALU result, same cycle
busy  output  1  high from the cycle after start acceptance until DONE
done  output  1  one-cycle pulse; results valid
result_lo  output  32  product low word or quotient; held until next accepted start
result_hi  output  32  remainder; 0 for multiply

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE. busy, done, result_lo and result_hi are 0. All internal registers are 0. Any operation in flight is aborted with no done pulse.
- States: IDLE, MUL, DIV_CMP, DIV_SUB, DONE. Bit counter is 6 bits.
- IDLE: ALU outputs are inputs=0, command=add. On start=1, the block latches operands, clears count, and goes to MUL (op=0) or DIV_CMP (op=1).
  - Multiply: acc=0, mcand=operand_a, mplier=operand_b.
  - Divide: rem=0, quo=operand_a, dvsr=operand_b.
- MUL (one cycle per bit): alu_input_1=acc, alu_input_2=mcand, command=add.
  - If mplier[0], acc<=alu_out.
  - mcand<<=1, mplier>>=1, count++.
  - After the 32nd cycle, go to DONE.
  - Arithmetic is mod 2^32; no HI word, no overflow flag.
- DIV_CMP: shifted={rem[30:0],quo[31]}, ovf=rem[31]. alu_input_1=shifted, alu_input_2=dvsr, command=SLT.
  - lt<=alu_out[0] & ~ovf. When ovf=1, the true shifted value is ≥2^32 > dvsr, so a subtract is forced.
  - rem<=shifted, quo<={quo[30:0],0}. Go to DIV_SUB.
- DIV_SUB: alu_input_1=rem, alu_input_2=dvsr, command=sub, always issued.
  - If !lt: rem<=alu_out and quo[0]<=1.
  - count++. After the 32nd DIV_SUB, go to DONE; else go to DIV_CMP.
- DONE (one cycle): done=1, busy=0.
  - result_lo<=acc (mul) or quo (div); result_hi<=0 (mul) or rem (div). Results are registered and visible in the DONE cycle.
  - Next state is IDLE.
- Latency from the start edge: multiply has done high in cycle 33; divide in cycle 65. The count is fixed, with no early termination.
- start while busy or in DONE: ignored, with no effect on the operation in flight or the latched inputs.
- Divide by zero: no special case. The natural result is quotient=0xFFFFFFFF, remainder=dividend.
- Operand changes after acceptance have no effect.
- ALU outputs are driven only from registered state; there are no combinational paths from start/op/operands to the ALU ports.

Test Plan:
- Reset, then start op=0 with a=7, b=6 → busy=1 for 32 cycles; done pulses in cycle 33; result_lo=42, result_hi=0; alu_command=000 throughout.
- Multiply a=0xFFFFFFFF, b=0xFFFFFFFF → result_lo=0x00000001 (wrap-around); a=0x12345678, b=0 → result_lo=0.
- Divide a=100, b=7 → done in cycle 65; result_lo=14, result_hi=2. Commands alternate 101/001.
- Divide a=0xFFFFFFFF, b=0x80000001 (ovf path) → result_lo=1, result_hi=0x7FFFFFFE. Divide a=5, b=0 → result_lo=0xFFFFFFFF, result_hi=5.
- Pulse start with new operands at cycle 10 of a multiply → ignored; original result is produced and done pulses exactly once.
- Assert reset at cycle 20 of a divide → busy, done and results go to 0 immediately (async). No done pulse follows. A new start after reset completes correctly.
